// File: rtl/portb_arbiter_if.sv
// Port bundle for portb_arbiter: both requester ports plus the BRAM port-B side.
// master = requesters and memory model; slave = the arbiter itself.
interface portb_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0;
  logic             req1;
  logic             we0;
  logic             we1;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  logic             rvalid0;
  logic             rvalid1;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] mem_q;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/portb_arbiter.sv
// Two-requester round-robin arbiter for BRAM port B with burst limiting and a
// two-stage read-return pipeline (grant -> BRAM read -> rdata/rvalid).
module portb_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAXBURST = 8
) (
  input  logic           clk,
  input  logic           reset,
  portb_arbiter_if.slave bus
);
  localparam int            CW         = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] BURST_MAX  = CW'(MAXBURST);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAXBURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_prio;
  logic [CW-1:0]    r_burst;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_entry;
  logic             w_burst_done;
  logic             r_s1_valid;
  logic             r_s1_side;
  logic             r_rvalid0;
  logic             r_rvalid1;
  logic [WIDTH-1:0] r_rdata0;
  logic [WIDTH-1:0] r_rdata1;

  // The counter saturates at MAXBURST, so >= also yields to a competitor that
  // shows up after a long uncontested run.
  assign w_burst_done = (r_burst >= BURST_LAST);
  assign w_entry      = (w_next != r_state) && (w_next != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_next       = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_data = '0;

    unique case (r_state)
      IDLE: begin
        if (bus.req0 && bus.req1) w_next = r_prio ? OWN1 : OWN0;
        else if (bus.req0)        w_next = OWN0;
        else if (bus.req1)        w_next = OWN1;
      end
      OWN0: begin
        w_gnt0 = bus.req0;
        if (!bus.req0)                     w_next = bus.req1 ? OWN1 : IDLE;
        else if (w_burst_done && bus.req1) w_next = OWN1;
      end
      OWN1: begin
        w_gnt1 = bus.req1;
        if (!bus.req1)                     w_next = bus.req0 ? OWN0 : IDLE;
        else if (w_burst_done && bus.req0) w_next = OWN0;
      end
      default: w_next = IDLE;
    endcase

    if (w_gnt0) begin
      bus.mem_we   = bus.we0;
      bus.mem_addr = bus.addr0;
      bus.mem_data = bus.wdata0;
    end else if (w_gnt1) begin
      bus.mem_we   = bus.we1;
      bus.mem_addr = bus.addr1;
      bus.mem_data = bus.wdata1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_burst <= '0;
    end else begin
      r_state <= w_next;
      if (w_entry) begin
        r_prio  <= (w_next == OWN0);
        r_burst <= '0;
      end else if ((w_gnt0 || w_gnt1) && (r_burst != BURST_MAX)) begin
        r_burst <= r_burst + CW'(1);
      end
    end
  end

  // Stage 1 remembers which side issued a read; stage 2 captures mem_q.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the rdata holding registers are reset too, so a discarded read can
    // never leak stale data out after reset.
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_side  <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_s1_valid <= (w_gnt0 && !bus.we0) || (w_gnt1 && !bus.we1);
      r_s1_side  <= w_gnt1;
      r_rvalid0  <= r_s1_valid && !r_s1_side;
      r_rvalid1  <= r_s1_valid && r_s1_side;
      if (r_s1_valid && !r_s1_side) r_rdata0 <= bus.mem_q;
      if (r_s1_valid && r_s1_side)  r_rdata1 <= bus.mem_q;
    end
  end

  assign bus.gnt0    = w_gnt0;
  assign bus.gnt1    = w_gnt1;
  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;
endmodule

// File: tb/tb_portb_arbiter.sv
// Self-checking bench for portb_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (owner/tenure, read-return queue, memory image).
module tb_portb_arbiter;
  localparam int WIDTH    = 16;
  localparam int MAXBURST = 8;

  typedef struct {
    int               due;
    int               side;
    logic [WIDTH-1:0] data;
  } rd_t;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             ld_en   = 1'b0;
  logic [7:0]       ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;
  logic [WIDTH-1:0] bram    [256];
  logic [WIDTH-1:0] ref_mem [256];
  int               tests_run    = 0;
  int               tests_failed = 0;

  portb_arbiter_if #(.WIDTH(WIDTH)) bus ();

  portb_arbiter #(.WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: one-cycle registered read, plus a bench-side load port.
  always @(posedge clk) begin
    if (bus.mem_we)  bram[bus.mem_addr[7:0]] <= bus.mem_data;
    else if (ld_en)  bram[ld_addr] <= ld_data;
    bus.mem_q <= bram[bus.mem_addr[7:0]];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.we0    = 1'b0;
    bus.we1    = 1'b0;
    bus.addr0  = '0;
    bus.addr1  = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
  endtask

  // Returns at a falling edge with reset still high; the caller releases it.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [WIDTH-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b1; bus.we1 = 1'b1;
    bus.addr0 = 16'h1111; bus.addr1 = 16'h2222;
    bus.wdata0 = 16'h3333; bus.wdata1 = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests_run++;
      if ({bus.gnt0, bus.gnt1, bus.mem_we, bus.rvalid0, bus.rvalid1} !== 5'b00000) begin
        tests_failed++;
        $display("FAIL reset_ctrl i=%0d: gnt0/gnt1/mem_we/rvalid0/rvalid1 got %b want 00000", i,
                 {bus.gnt0, bus.gnt1, bus.mem_we, bus.rvalid0, bus.rvalid1});
      end
      tests_run++;
      if ({bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_data} !== {4*WIDTH{1'b0}}) begin
        tests_failed++;
        $display("FAIL reset_data i=%0d: rdata0=%h rdata1=%h mem_addr=%h mem_data=%h want all 0",
                 i, bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_single_read();
    load(8'h10, 16'h1234);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) reset = 1'b0; else @(negedge clk);
      bus.req0 = (c < 2); bus.we0 = 1'b0; bus.addr0 = 16'h0010;
      #1;
      tests_run++;
      if ({bus.gnt0, bus.gnt1} !== {(c == 1), 1'b0}) begin
        tests_failed++;
        $display("FAIL single_read_gnt c=%0d: gnt0/gnt1 got %b want %b0", c, {bus.gnt0, bus.gnt1}, (c == 1));
      end
      tests_run++;
      if (bus.rvalid0 !== (c == 3)) begin
        tests_failed++;
        $display("FAIL single_read_rvalid c=%0d: got %b want %b", c, bus.rvalid0, (c == 3));
      end
      if (c >= 3) begin
        tests_run++;
        if (bus.rdata0 !== 16'h1234) begin
          tests_failed++;
          $display("FAIL single_read_rdata c=%0d: got %h want 1234", c, bus.rdata0);
        end
      end
      if (c == 1) begin
        tests_run++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, 16'h0010}) begin
          tests_failed++;
          $display("FAIL single_read_mem: mem_we=%b mem_addr=%h want 0/0010", bus.mem_we, bus.mem_addr);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_pass();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) reset = 1'b0; else @(negedge clk);
      bus.req1 = (c < 2); bus.we1 = 1'b1; bus.addr1 = 16'h0305; bus.wdata1 = 16'h00AA;
      #1;
      tests_run++;
      if ({bus.gnt0, bus.gnt1, bus.mem_we} !== {1'b0, (c == 1), (c == 1)}) begin
        tests_failed++;
        $display("FAIL write_ctrl c=%0d: gnt0/gnt1/mem_we got %b want 0%b%b", c,
                 {bus.gnt0, bus.gnt1, bus.mem_we}, (c == 1), (c == 1));
      end
      tests_run++;
      if ({bus.mem_addr, bus.mem_data} !== ((c == 1) ? {16'h0305, 16'h00AA} : 32'h0)) begin
        tests_failed++;
        $display("FAIL write_bus c=%0d: mem_addr=%h mem_data=%h", c, bus.mem_addr, bus.mem_data);
      end
      tests_run++;
      if (bus.rvalid1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL write_rvalid c=%0d: rvalid1 got %b want 0", c, bus.rvalid1);
      end
    end
    tests_run++;
    if (bram[8'h05] !== 16'h00AA) begin
      tests_failed++;
      $display("FAIL write_mem: bram[05] got %h want 00aa", bram[8'h05]);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_g;
    do_reset();
    for (int c = 0; c < 4 * MAXBURST + 4; c++) begin
      if (c == 0) reset = 1'b0; else @(negedge clk);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      bus.addr0 = 16'h0001; bus.addr1 = 16'h0002;
      #1;
      if (c == 0) exp_g = 2'b00;
      else        exp_g = ((((c - 1) / MAXBURST) % 2) == 0) ? 2'b10 : 2'b01;
      tests_run++;
      if ({bus.gnt0, bus.gnt1} !== exp_g) begin
        tests_failed++;
        $display("FAIL simultaneous c=%0d: gnt0/gnt1 got %b want %b", c, {bus.gnt0, bus.gnt1}, exp_g);
      end
    end
    idle_inputs();
  endtask

  task automatic test_early_release();
    logic [1:0] exp_g;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c == 0) reset = 1'b0; else @(negedge clk);
      bus.req0 = (c < 4); bus.req1 = 1'b1;
      #1;
      if (c >= 1 && c <= 3) exp_g = 2'b10;
      else if (c >= 5)      exp_g = 2'b01;
      else                  exp_g = 2'b00;
      tests_run++;
      if ({bus.gnt0, bus.gnt1} !== exp_g) begin
        tests_failed++;
        $display("FAIL early_release c=%0d: gnt0/gnt1 got %b want %b", c, {bus.gnt0, bus.gnt1}, exp_g);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stream_reads();
    logic [WIDTH-1:0] vals [4];
    vals[0] = 16'hBEEF; vals[1] = 16'hCAFE; vals[2] = 16'h0F0F; vals[3] = 16'h7531;
    for (int i = 0; i < 4; i++) load(8'h20 + 8'(i), vals[i]);
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c == 0) reset = 1'b0; else @(negedge clk);
      bus.req1  = (c <= 4);
      bus.we1   = 1'b0;
      bus.addr1 = 16'h0020 + 16'((c == 0) ? 0 : c - 1);
      #1;
      tests_run++;
      if ({bus.rvalid0, bus.rvalid1} !== {1'b0, (c >= 3 && c <= 6)}) begin
        tests_failed++;
        $display("FAIL stream_rvalid c=%0d: rvalid0/rvalid1 got %b want 0%b", c,
                 {bus.rvalid0, bus.rvalid1}, (c >= 3 && c <= 6));
      end
      if (c >= 3) begin
        tests_run++;
        if (bus.rdata1 !== vals[(c <= 6) ? c - 3 : 3]) begin
          tests_failed++;
          $display("FAIL stream_rdata c=%0d: got %h want %h", c, bus.rdata1, vals[(c <= 6) ? c - 3 : 3]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    load(8'h10, 16'h1234);
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c == 0) reset = 1'b0; else @(negedge clk);
      if (c == 3) reset = 1'b1;
      if (c == 5) reset = 1'b0;
      bus.req0 = (c < 3) || (c >= 5);
      bus.req1 = (c >= 5);
      bus.we0 = 1'b0; bus.addr0 = 16'h0010; bus.addr1 = 16'h0010;
      #1;
      if (c == 3) begin
        tests_run++;
        if ({bus.gnt0, bus.gnt1, bus.mem_we, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
             bus.mem_addr} !== {5'b0, {3*WIDTH{1'b0}}}) begin
          tests_failed++;
          $display("FAIL reset_mid_read_outputs: gnt=%b%b mem_we=%b rvalid=%b%b rdata0=%h rdata1=%h mem_addr=%h",
                   bus.gnt0, bus.gnt1, bus.mem_we, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1, bus.mem_addr);
        end
      end
      if (c >= 3 && c <= 7) begin
        tests_run++;
        if (bus.rvalid0 !== 1'b0) begin
          tests_failed++;
          $display("FAIL reset_mid_read_rvalid c=%0d: got %b want 0", c, bus.rvalid0);
        end
      end
      if (c >= 5) begin
        tests_run++;
        if ({bus.gnt0, bus.gnt1} !== ((c == 5) ? 2'b00 : 2'b10)) begin
          tests_failed++;
          $display("FAIL reset_mid_read_prio c=%0d: gnt0/gnt1 got %b want %b", c,
                   {bus.gnt0, bus.gnt1}, ((c == 5) ? 2'b00 : 2'b10));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int               owner;
    int               rr;
    int               tenure;
    int               nxt;
    int               s;
    rd_t              pend [$];
    rd_t              e;
    logic             rq [2];
    logic             wq [2];
    logic [WIDTH-1:0] aq [2];
    logic [WIDTH-1:0] dq [2];
    logic [WIDTH-1:0] exp_rd [2];
    logic [1:0]       exp_v;
    logic             exp_g0, exp_g1, exp_we;
    logic [WIDTH-1:0] exp_addr, exp_data;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'($urandom);
      load(8'(i), ref_mem[i]);
    end
    do_reset();
    owner = -1; rr = 0; tenure = 0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;

    for (int c = 0; c < 800; c++) begin
      if (c == 0) reset = 1'b0; else @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 99) < 15) rq[k] = !rq[k];
        wq[k] = ($urandom_range(0, 2) == 0);
        aq[k] = 16'($urandom);
        dq[k] = 16'($urandom);
      end
      bus.req0 = rq[0]; bus.we0 = wq[0]; bus.addr0 = aq[0]; bus.wdata0 = dq[0];
      bus.req1 = rq[1]; bus.we1 = wq[1]; bus.addr1 = aq[1]; bus.wdata1 = dq[1];
      #1;

      exp_g0 = (owner == 0) && rq[0];
      exp_g1 = (owner == 1) && rq[1];
      exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      if (exp_g0 || exp_g1) begin
        s = exp_g0 ? 0 : 1;
        exp_we = wq[s]; exp_addr = aq[s]; exp_data = dq[s];
      end
      exp_v = 2'b00;
      if (pend.size() > 0 && pend[0].due == c) begin
        exp_v[pend[0].side] = 1'b1;
        exp_rd[pend[0].side] = pend[0].data;
        pend.delete(0);
      end

      tests_run++;
      if ({bus.gnt0, bus.gnt1} !== {exp_g0, exp_g1}) begin
        tests_failed++;
        $display("FAIL random_gnt c=%0d: gnt0/gnt1 got %b want %b", c, {bus.gnt0, bus.gnt1}, {exp_g0, exp_g1});
      end
      tests_run++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_data} !== {exp_we, exp_addr, exp_data}) begin
        tests_failed++;
        $display("FAIL random_mem c=%0d: we/addr/data got %b/%h/%h want %b/%h/%h", c,
                 bus.mem_we, bus.mem_addr, bus.mem_data, exp_we, exp_addr, exp_data);
      end
      tests_run++;
      if ({bus.rvalid1, bus.rvalid0} !== exp_v) begin
        tests_failed++;
        $display("FAIL random_rvalid c=%0d: rvalid1/rvalid0 got %b want %b", c, {bus.rvalid1, bus.rvalid0}, exp_v);
      end
      tests_run++;
      if ({bus.rdata0, bus.rdata1} !== {exp_rd[0], exp_rd[1]}) begin
        tests_failed++;
        $display("FAIL random_rdata c=%0d: rdata0/rdata1 got %h/%h want %h/%h", c,
                 bus.rdata0, bus.rdata1, exp_rd[0], exp_rd[1]);
      end

      // Advance the model: account for this cycle's access, then decide next owner.
      if (exp_g0 || exp_g1) begin
        tenure++;
        if (wq[s]) begin
          ref_mem[aq[s][7:0]] = dq[s];
        end else begin
          e.due = c + 2; e.side = s; e.data = ref_mem[aq[s][7:0]];
          pend.push_back(e);
        end
      end
      nxt = owner;
      if (owner < 0) begin
        if (rq[0] && rq[1]) nxt = rr;
        else if (rq[0])     nxt = 0;
        else if (rq[1])     nxt = 1;
      end else if (!rq[owner]) begin
        nxt = rq[1 - owner] ? 1 - owner : -1;
      end else if (tenure >= MAXBURST && rq[1 - owner]) begin
        nxt = 1 - owner;
      end
      if (nxt >= 0 && nxt != owner) begin
        rr = 1 - nxt;
        tenure = 0;
      end
      owner = nxt;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_pass();
    test_simultaneous();
    test_early_release();
    test_stream_reads();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/portb_arbiter.md
PORTB_ARBITER -- requirements
Module: portb_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 16, data and address width.
- MAXBURST, 8, maximum consecutive granted cycles per owner while the other side waits.
REQ-002 Ports (name  direction  width  meaning), one per line:
- clk  in  1  single clock, rising-edge.
- reset  in  1  reset; asynchronous, active-high.
- req0 / req1  in  1  requester 0/1 access request, one access per cycle while granted.
- we0 / we1  in  1  requester write enable, qualified by own grant.
- addr0 / addr1  in  WIDTH  requester address.
- wdata0 / wdata1  in  WIDTH  requester write data.
- gnt0 / gnt1  out  1  access accepted this cycle.
- rdata0 / rdata1  out  WIDTH  read data returned to requester.
- rvalid0 / rvalid1  out  1  rdata valid, one-cycle pulse per granted read.
- mem_we  out  1  BRAM port-B write enable.
- mem_addr  out  WIDTH  BRAM port-B address.
- mem_data  out  WIDTH  BRAM port-B write data.
- mem_q  in  WIDTH  BRAM port-B read data, valid the cycle after the address is presented.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, OWN0, OWN1, updated on the rising edge of clk.
REQ-004 gntX SHALL be combinational: gntX = (state==OWNX) & reqX; gnt0 and gnt1 SHALL never be high together.
REQ-005 From IDLE, a single requester X SHALL move the FSM to OWNX.
- No grant occurs in the IDLE cycle; arbitration latency is 1 cycle.
REQ-006 From IDLE, simultaneous req0 & req1 SHALL go to OWN(prio), where prio is the round-robin pointer.
REQ-007 On every entry to OWNX, prio SHALL be set to the other requester and the burst counter SHALL be cleared.
REQ-008 In OWNX, each cycle with gntX high SHALL increment the burst counter; the counter SHALL saturate at MAXBURST.
REQ-009 In OWNX, if reqX is low, the FSM SHALL go to OWN(other) when the other requester is requesting, else to IDLE.
REQ-010 In OWNX, if the burst counter equals MAXBURST-1 at a granted cycle and the other requester is requesting, the FSM SHALL go to OWN(other).
- The owner then loses grant after exactly MAXBURST accesses.
REQ-011 In OWNX with only reqX asserted, ownership SHALL persist indefinitely; no switch occurs without a competing request.
REQ-012 Memory port drive SHALL be a combinational mux by grant:
- mem_addr / mem_data = addrX / wdataX of the granted side.
- mem_we = gntX & weX.
- With no grant: mem_we = 0, mem_addr = 0, mem_data = 0.
REQ-013 A granted read (gntX & ~weX) in cycle N SHALL be handled as follows:
- mem_q is registered at the end of cycle N+1.
- rdataX holds it and rvalidX is high for exactly cycle N+2; latency from grant is 2 cycles.
REQ-014 Granted writes SHALL produce no rvalid pulse.
REQ-015 Reads in back-to-back cycles SHALL produce back-to-back rvalid pulses in order, including across an ownership switch; the read pipeline is fully pipelined with depth 2.
REQ-016 rdataX SHALL hold its last value when rvalidX is low; rdata of the non-returning side SHALL be unchanged.

Reset
REQ-017 reset high SHALL asynchronously force all of the following, regardless of operation in progress:
- state = IDLE, prio = 0, burst counter = 0.
- Both read-pipeline stages invalid.
- rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0.
- Outstanding reads are discarded, never returned.
REQ-018 While reset is high, gnt0, gnt1 and mem_we SHALL be 0.
REQ-019 The first arbitration SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-020 The bench SHALL cover these scenarios (MAXBURST=8):
- Single read: req0=1, we0=0, addr0=0x0010, mem_q=0x1234 the cycle after grant -> gnt0 high in cycle 1; rdata0=0x1234 with a one-cycle rvalid0 in cycle 3; gnt1 never high.
- Write pass-through: req1=1, we1=1, addr1=0x0305, wdata1=0x00AA -> in the granted cycle mem_we=1, mem_addr=0x0305, mem_data=0x00AA; rvalid1 stays 0.
- Simultaneous first request: req0 and req1 held from reset release -> OWN0 first; exactly 8 gnt0 cycles, then 8 gnt1 cycles, alternating; grants never overlap.
- Early release: req0 drops after 3 grants while req1 is held -> gnt1 high on the next cycle, with no IDLE cycle between.
- Streaming reads: 4 consecutive reads by requester 1 -> 4 consecutive rvalid1 pulses carrying the 4 mem_q values in order.
- Reset mid-read: reset pulsed one cycle after a granted read -> no rvalid pulse; all outputs 0; state IDLE with prio 0.
